key_capture: RTL and testbench
==============================

KEY_CAPTURE -- requirements
Module: key_capture

Interface
REQ-001 SHALL provide parameter DEBOUNCE_CYCLES, default 4, number of consecutive stable clocks required before an input vector is accepted; legal range 2..255.
REQ-002 SHALL provide port clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL provide port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL provide port key_in  input  8  raw, asynchronous, bouncing key lines; bit i high = key i pressed.
REQ-005 SHALL provide port ack  input  1  consumer acknowledge of the presented code.
REQ-006 SHALL provide port onehot  output  8  captured key, exactly one bit set while valid; feeds the downstream 8-to-3 encoder.
REQ-007 SHALL provide port valid  output  1  onehot holds a new unacknowledged key.
REQ-008 SHALL provide port multi  output  1  more than one key was stable at capture.

Function
REQ-009 SHALL synchronise key_in through two flops (s1, s2) and keep a third copy s3 of the previous s2 value; change = (s2 != s3).
REQ-010 SHALL keep a stability counter cnt, width sufficient for DEBOUNCE_CYCLES: cleared on any edge where change=1, else incremented, saturating at DEBOUNCE_CYCLES.
REQ-011 SHALL load debounced vector deb <= s2 on the edge where change=0 and cnt == DEBOUNCE_CYCLES-1.
REQ-012 SHALL implement FSM states IDLE, HOLD, RELEASE.
REQ-013 IDLE: when deb != 0, SHALL on the next edge set onehot to the lowest-index set bit of deb, valid=1, multi=1 iff popcount(deb)>1, go HOLD; deb==0 stays IDLE.
REQ-014 HOLD: onehot, valid, multi SHALL stay constant regardless of key_in; on edge with ack=1 SHALL clear onehot, valid, multi and go RELEASE.
REQ-015 RELEASE: SHALL stay until deb==0, then go IDLE on that edge; no new capture while any debounced key remains held.
REQ-016 Latency: key_in stable from before edge 1 SHALL produce valid=1 after edge DEBOUNCE_CYCLES+4 (edge 8 at default).
REQ-017 Bounce: any s2 change restarts the count; no capture SHALL occur until DEBOUNCE_CYCLES+1 unchanged s2 samples.
REQ-018 ack while valid=0 (IDLE or RELEASE) SHALL be ignored.
REQ-019 Key released during HOLD: valid and onehot SHALL persist until ack; RELEASE then exits when deb reaches 0.
REQ-020 New key pressed during HOLD or RELEASE SHALL NOT overwrite onehot; only the release-then-press sequence yields a new capture.
REQ-021 ack and a deb update on the same edge: the FSM SHALL use the pre-edge deb value.

Reset
REQ-022 rst=1 SHALL immediately force s1, s2, s3, deb, cnt, onehot, valid, multi to 0 and FSM to IDLE, independent of clk.
REQ-023 Reset mid-HOLD SHALL discard the pending code; keys still held after deassertion SHALL be recaptured with full REQ-016 latency measured from the first edge after deassertion.

Verification
REQ-024 Single key: key_in=8'h08 held, D=4 -> valid=1, onehot=8'h08, multi=0 after edge 8, not before.
REQ-025 Bounce: bit 5 toggled every 2 clocks for 12 clocks then held high -> valid stays 0 throughout bounce; valid=1, onehot=8'h20 DEBOUNCE_CYCLES+4 edges after last key_in change.
REQ-026 Two keys: key_in=8'h24 -> onehot=8'h04, multi=1; ack -> valid=0, multi=0 next edge; no recapture while 8'h24 held; release then press 8'h80 -> onehot=8'h80.
REQ-027 Release before ack: capture 8'h01, drop key_in to 0, wait 20 clocks -> valid still 1, onehot=8'h01; ack -> valid=0, FSM back in IDLE within DEBOUNCE_CYCLES+4 edges.
REQ-028 Reset in HOLD: rst pulsed between edges with 8'h10 held -> outputs 0 before next edge; valid=1, onehot=8'h10 after edge DEBOUNCE_CYCLES+4 post-deassertion.
REQ-029 Spurious ack: ack=1 for 5 clocks in IDLE with key_in=0 -> valid, onehot, multi remain 0.

Source files
------------

// File: rtl/key_capture.sv
// key_capture: debounces an 8-bit bank of raw key lines, captures the
// lowest-index pressed key as a one-hot code and holds it until the
// consumer acknowledges. A new capture is only possible after every
// debounced key has been released.
module key_capture #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] key_in,
  input  logic       ack,
  output logic [7:0] onehot,
  output logic       valid,
  output logic       multi
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LOAD = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  logic [7:0]    r_s1;
  logic [7:0]    r_s2;
  logic [7:0]    r_s3;
  logic [7:0]    r_deb;
  logic [CW-1:0] r_cnt;
  state_t        r_state;
  logic [7:0]    r_onehot;
  logic          r_valid;
  logic          r_multi;

  logic          w_change;
  logic [7:0]    w_lowest;
  logic          w_multi;

  // s3 lags s2 by one clock, so any difference means the synchronised
  // input moved on this cycle and the stability window must restart.
  assign w_change = (r_s2 != r_s3);

  // Two's-complement trick isolates the lowest set bit of the debounced
  // vector; clearing that bit leaves something only if two or more keys
  // are down.
  assign w_lowest = r_deb & (~r_deb + 8'd1);
  assign w_multi  = ((r_deb & (r_deb - 8'd1)) != 8'd0);

  // Two-flop synchroniser for the asynchronous key lines plus a history copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= 8'd0;
      r_s2 <= 8'd0;
      r_s3 <= 8'd0;
    end else begin
      r_s1 <= key_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // Stability counter and debounced vector: the vector is accepted once
  // the synchronised input has been unchanged for the full window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_deb <= 8'd0;
    end else begin
      if (w_change) begin
        r_cnt <= '0;
      end else begin
        if (r_cnt != CNT_MAX) begin
          r_cnt <= r_cnt + 1'b1;
        end
        if (r_cnt == CNT_LOAD) begin
          r_deb <= r_s2;
        end
      end
    end
  end

  // Capture FSM: IDLE captures, HOLD presents until ack, RELEASE waits for
  // every debounced key to lift so a held key cannot be captured twice.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_onehot <= 8'd0;
      r_valid  <= 1'b0;
      r_multi  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (r_deb != 8'd0) begin
            r_onehot <= w_lowest;
            r_valid  <= 1'b1;
            r_multi  <= w_multi;
            r_state  <= HOLD;
          end
        end
        HOLD: begin
          if (ack) begin
            r_onehot <= 8'd0;
            r_valid  <= 1'b0;
            r_multi  <= 1'b0;
            r_state  <= RELEASE;
          end
        end
        RELEASE: begin
          if (r_deb == 8'd0) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_onehot <= 8'd0;
          r_valid  <= 1'b0;
          r_multi  <= 1'b0;
        end
      endcase
    end
  end

  assign onehot = r_onehot;
  assign valid  = r_valid;
  assign multi  = r_multi;

endmodule

// File: tb/tb_key_capture.sv
// tb_key_capture: directed scenarios with literal expectations, followed by
// randomized key/ack traffic compared every cycle against a behavioural
// model built from input-history run lengths.
module tb_key_capture;

  localparam int DEB = 4;

  logic       clk    = 1'b0;
  logic       rst    = 1'b1;
  logic [7:0] key_in = 8'd0;
  logic       ack    = 1'b0;
  logic [7:0] onehot;
  logic       valid;
  logic       multi;

  int checks = 0;
  int passes = 0;

  key_capture #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk    (clk),
    .rst    (rst),
    .key_in (key_in),
    .ack    (ack),
    .onehot (onehot),
    .valid  (valid),
    .multi  (multi)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Reference model state: every key_in sample since the last reset, plus
  // the presented code and whether a release is still owed.
  logic [7:0] hist[$];
  logic [7:0] mDeb     = 8'd0;
  logic [7:0] mOnehot  = 8'd0;
  logic       mValid   = 1'b0;
  logic       mMulti   = 1'b0;
  logic       mWaitRel = 1'b0;
  logic [7:0] nextDeb;
  int         lastIdx;

  // Length of the run of identical samples ending at index last. The
  // implicit all-zero history before reset makes a zero run unbounded.
  function automatic int runLen(int last);
    logic [7:0] v;
    int j;
    int r;
    v = hist[last];
    j = last;
    r = 0;
    while (j >= 0 && hist[j] == v && r <= DEB + 1) begin
      r++;
      j--;
    end
    if (j < 0 && v == 8'd0) r += 1000;
    return r;
  endfunction

  function automatic logic [7:0] lowestKey(logic [7:0] v);
    logic [7:0] r;
    r = 8'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) r = 8'd1 << i;
    end
    return r;
  endfunction

  // Model: the debounced vector takes a value once the input seen two
  // clocks ago has been steady for exactly DEB+1 samples; the capture
  // logic works from the debounced value held before the edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hist.delete();
      mDeb     = 8'd0;
      mOnehot  = 8'd0;
      mValid   = 1'b0;
      mMulti   = 1'b0;
      mWaitRel = 1'b0;
    end else begin
      hist.push_back(key_in);
      nextDeb = mDeb;
      lastIdx = hist.size() - 3;
      if (lastIdx >= 0 && runLen(lastIdx) == DEB + 1) nextDeb = hist[lastIdx];
      if (mValid) begin
        if (ack) begin
          mValid   = 1'b0;
          mOnehot  = 8'd0;
          mMulti   = 1'b0;
          mWaitRel = 1'b1;
        end
      end else if (mWaitRel) begin
        if (mDeb == 8'd0) mWaitRel = 1'b0;
      end else if (mDeb != 8'd0) begin
        mValid  = 1'b1;
        mOnehot = lowestKey(mDeb);
        mMulti  = ($countones(mDeb) > 1);
      end
      mDeb = nextDeb;
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Per-cycle comparison of the DUT outputs against the model.
  always @(negedge clk) begin
    checkOutput("model_onehot", onehot, mOnehot);
    checkOutput("model_valid", {7'd0, valid}, {7'd0, mValid});
    checkOutput("model_multi", {7'd0, multi}, {7'd0, mMulti});
  end

  task automatic applyStimulus(input logic [7:0] keys, input logic ackVal, input int n);
    key_in = keys;
    ack    = ackVal;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulseReset();
    #1 rst = 1'b1;
    #1;
    checkOutput("rst_onehot", onehot, 8'h00);
    checkOutput("rst_valid", {7'd0, valid}, 8'h00);
    checkOutput("rst_multi", {7'd0, multi}, 8'h00);
    #1 rst = 1'b0;
  endtask

  logic [7:0] rk;

  initial begin
    $display("[TB] start");
    repeat (3) @(negedge clk);
    checkOutput("reset_onehot", onehot, 8'h00);
    checkOutput("reset_valid", {7'd0, valid}, 8'h00);
    checkOutput("reset_multi", {7'd0, multi}, 8'h00);
    rst = 1'b0;

    // Single key: capture appears after edge DEB+4, not before.
    applyStimulus(8'h08, 1'b0, DEB + 3);
    checkOutput("single_early_valid", {7'd0, valid}, 8'h00);
    applyStimulus(8'h08, 1'b0, 1);
    checkOutput("single_valid", {7'd0, valid}, 8'h01);
    checkOutput("single_onehot", onehot, 8'h08);
    checkOutput("single_multi", {7'd0, multi}, 8'h00);
    applyStimulus(8'h08, 1'b1, 1);
    checkOutput("single_ack_valid", {7'd0, valid}, 8'h00);
    applyStimulus(8'h00, 1'b0, 12);

    // Spurious ack in IDLE.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(8'h00, 1'b1, 1);
      checkOutput("spurious_valid", {7'd0, valid}, 8'h00);
      checkOutput("spurious_onehot", onehot, 8'h00);
      checkOutput("spurious_multi", {7'd0, multi}, 8'h00);
    end
    applyStimulus(8'h00, 1'b0, 2);

    // Bounce on bit 5, then held high.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(((i % 4) < 2) ? 8'h20 : 8'h00, 1'b0, 1);
      checkOutput("bounce_valid", {7'd0, valid}, 8'h00);
    end
    applyStimulus(8'h20, 1'b0, DEB + 3);
    checkOutput("bounce_early_valid", {7'd0, valid}, 8'h00);
    applyStimulus(8'h20, 1'b0, 1);
    checkOutput("bounce_valid_final", {7'd0, valid}, 8'h01);
    checkOutput("bounce_onehot", onehot, 8'h20);
    applyStimulus(8'h20, 1'b1, 1);
    applyStimulus(8'h00, 1'b0, 12);

    // Two keys: lowest wins, multi flagged, no recapture while held.
    applyStimulus(8'h24, 1'b0, DEB + 4);
    checkOutput("two_valid", {7'd0, valid}, 8'h01);
    checkOutput("two_onehot", onehot, 8'h04);
    checkOutput("two_multi", {7'd0, multi}, 8'h01);
    applyStimulus(8'h24, 1'b1, 1);
    checkOutput("two_ack_valid", {7'd0, valid}, 8'h00);
    checkOutput("two_ack_multi", {7'd0, multi}, 8'h00);
    applyStimulus(8'h24, 1'b0, 15);
    checkOutput("two_held_valid", {7'd0, valid}, 8'h00);
    checkOutput("two_held_onehot", onehot, 8'h00);
    applyStimulus(8'h00, 1'b0, 12);
    applyStimulus(8'h80, 1'b0, DEB + 4);
    checkOutput("two_next_onehot", onehot, 8'h80);
    checkOutput("two_next_multi", {7'd0, multi}, 8'h00);
    applyStimulus(8'h80, 1'b1, 1);
    applyStimulus(8'h00, 1'b0, 12);

    // Release before ack: code persists, then FSM returns to IDLE.
    applyStimulus(8'h01, 1'b0, DEB + 4);
    checkOutput("rel_valid", {7'd0, valid}, 8'h01);
    applyStimulus(8'h00, 1'b0, 20);
    checkOutput("rel_hold_valid", {7'd0, valid}, 8'h01);
    checkOutput("rel_hold_onehot", onehot, 8'h01);
    applyStimulus(8'h00, 1'b1, 1);
    checkOutput("rel_ack_valid", {7'd0, valid}, 8'h00);
    applyStimulus(8'h00, 1'b0, 1);
    applyStimulus(8'h02, 1'b0, DEB + 4);
    checkOutput("rel_next_onehot", onehot, 8'h02);
    applyStimulus(8'h02, 1'b1, 1);
    applyStimulus(8'h00, 1'b0, 12);

    // Reset while holding a code with the key still pressed.
    applyStimulus(8'h10, 1'b0, DEB + 4);
    checkOutput("hold_rst_pre_valid", {7'd0, valid}, 8'h01);
    pulseReset();
    repeat (DEB + 3) @(negedge clk);
    checkOutput("hold_rst_early_valid", {7'd0, valid}, 8'h00);
    @(negedge clk);
    checkOutput("hold_rst_valid", {7'd0, valid}, 8'h01);
    checkOutput("hold_rst_onehot", onehot, 8'h10);
    applyStimulus(8'h10, 1'b1, 1);
    applyStimulus(8'h00, 1'b0, 12);

    // Randomized traffic, checked by the per-cycle model comparison.
    rk = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0: rk = 8'h00;
          1: rk = 8'd1 << $urandom_range(0, 7);
          2: rk = 8'($urandom);
          default: rk = key_in ^ (8'd1 << $urandom_range(0, 7));
        endcase
      end
      if ($urandom_range(0, 499) == 0) pulseReset();
      applyStimulus(rk, ($urandom_range(0, 4) == 0), 1);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
